// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// master = the loader, slave = the byte source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    // Valid/ready: a byte moves on any rising edge where byte_valid && byte_ready.
    // The source holds byte_data stable while byte_valid is high and the byte is not yet taken.
    // imem_we is a one-cycle strobe, and imem_addr/imem_wdata are valid only while it is high.
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length/payload/checksum byte frame, writes payload words
// into instruction memory and releases the core only after a frame with a good checksum.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    imem_loader_if.master        bus,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // Largest legal word count; 17 bits so ADDR_W up to 16 still fits.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    state_t      state;
    logic [7:0]  len_lo;
    logic [7:0]  acc;
    logic [1:0]  byte_idx;
    logic [16:0] word_cnt;
    logic [16:0] word_idx;
    logic [31:0] asm_word;

    logic        xfer;
    logic [16:0] len_full;
    logic [31:0] word_next;

    assign xfer      = bus.byte_valid && bus.byte_ready;
    assign len_full  = {1'b0, bus.byte_data, len_lo};
    // Little-endian assembly: after four shifts the first byte sits in bits 7:0.
    assign word_next = {bus.byte_data, asm_word[31:8]};
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            len_lo         <= 8'd0;
            acc            <= 8'd0;
            byte_idx       <= 2'd0;
            word_cnt       <= 17'd0;
            word_idx       <= 17'd0;
            asm_word       <= 32'd0;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= 32'd0;
            cpu_reset      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state          <= S_LEN0;
                        acc            <= 8'd0;
                        byte_idx       <= 2'd0;
                        word_idx       <= 17'd0;
                        bus.byte_ready <= 1'b1;
                        busy           <= 1'b1;
                        cpu_reset      <= 1'b1;
                        done           <= 1'b0;
                        error          <= 1'b0;
                    end
                end
                S_LEN0: begin
                    if (xfer) begin
                        len_lo <= bus.byte_data;
                        acc    <= acc ^ bus.byte_data;
                        state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        acc      <= acc ^ bus.byte_data;
                        word_cnt <= len_full;
                        if (len_full > CAPACITY) begin
                            state          <= S_ERR;
                            bus.byte_ready <= 1'b0;
                            busy           <= 1'b0;
                            error          <= 1'b1;
                        end else if (len_full == 17'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        acc      <= acc ^ bus.byte_data;
                        asm_word <= word_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= word_idx[ADDR_W-1:0];
                            bus.imem_wdata <= word_next;
                            word_idx       <= word_idx + 17'd1;
                            // Leaving DATA here is what stops the index wrapping past capacity.
                            if (word_idx + 17'd1 == word_cnt) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        bus.byte_ready <= 1'b0;
                        busy           <= 1'b0;
                        if (bus.byte_data == acc) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W = 2 so the capacity and oversize edges are reachable).
// A frame-level model predicts writes and outcome; a per-cycle monitor checks them.
module tb_imem_loader;

    localparam int ADDR_W = 2;
    localparam int CAP    = 1 << ADDR_W;

    logic       clk;
    logic       reset;
    logic       start;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] state_dbg;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus.master),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [ADDR_W+31:0] exp_q[$];
    int   n_assert;
    int   n_fail;
    int   wr_count;
    int   exp_writes;
    logic check_en;
    logic prev_we;

    logic [7:0] f_basic[$];
    logic [7:0] f_bad[$];
    logic [7:0] f_zero[$];
    logic [7:0] f_over[$];
    logic [7:0] f_full[$];
    logic [7:0] f_part[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    function automatic logic [7:0] xor_bytes(input logic [7:0] fr[$], input int cnt);
        logic [7:0] a;
        a = 8'd0;
        for (int i = 0; i < cnt; i++) a ^= fr[i];
        return a;
    endfunction

    // Queues the expected writes and returns 1 when the frame must end in DONE.
    function automatic logic model_frame(input logic [7:0] fr[$]);
        int n;
        n = int'({fr[1], fr[0]});
        if (n > CAP) begin
            exp_writes = 0;
            return 1'b0;
        end
        for (int w = 0; w < n; w++)
            exp_q.push_back({ADDR_W'(w), fr[2+4*w+3], fr[2+4*w+2], fr[2+4*w+1], fr[2+4*w]});
        exp_writes = n;
        return fr[2+4*n] == xor_bytes(fr, 2 + 4*n);
    endfunction

    // ---------------- per-cycle monitor ----------------
    always @(negedge clk) begin
        if (check_en) begin
            check("ready_eq_busy", {63'd0, bus.byte_ready}, {63'd0, busy});
            check("cpu_reset_eq_not_done", {63'd0, cpu_reset}, {63'd0, ~done});
            check("done_and_error_exclusive", {63'd0, done & error}, 64'd0);
            if (bus.imem_we) begin
                check("we_single_cycle", {63'd0, prev_we}, 64'd0);
                wr_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {30'd0, bus.imem_addr, bus.imem_wdata}, 64'hDEAD);
                end else begin
                    check("write_addr_data", {30'd0, bus.imem_addr, bus.imem_wdata},
                          {30'd0, exp_q.pop_front()});
                end
            end
            prev_we = bus.imem_we;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", {63'd0, busy}, 64'd1);
        check("start_ready", {63'd0, bus.byte_ready}, 64'd1);
        check("start_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("start_done_clear", {62'd0, done, error}, 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic gaps);
        logic accepted;
        int   t;
        if (gaps) begin
            bus.byte_valid = 1'b0;
            idle($urandom_range(0, 3));
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        accepted = 1'b0;
        t = 0;
        while (!accepted && t < 50) begin
            @(negedge clk);
            if (bus.byte_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
            t++;
        end
        bus.byte_valid = 1'b0;
        check("byte_accepted", {63'd0, accepted}, 64'd1);
    endtask

    task automatic run_frame(input logic [7:0] fr[$], input logic gaps, input logic mid_start);
        logic ok;
        ok = model_frame(fr);
        wr_count = 0;
        pulse_start();
        for (int i = 0; i < fr.size(); i++) begin
            if (mid_start && i == 2) begin
                start = 1'b1;
                idle(1);
                start = 1'b0;
            end
            send_byte(fr[i], gaps);
        end
        check("end_done", {63'd0, done}, {63'd0, ok});
        check("end_error", {63'd0, error}, {63'd0, ~ok});
        check("end_cpu_reset", {63'd0, cpu_reset}, {63'd0, ~ok});
        check("end_ready_low", {63'd0, bus.byte_ready}, 64'd0);
        idle(3);
        check("write_count", 64'(wr_count), 64'(exp_writes));
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_assert = 0;
        n_fail   = 0;
        wr_count = 0;
        check_en = 1'b0;
        prev_we  = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;

        f_basic = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h63};
        f_bad   = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h62};
        f_zero  = '{8'h00, 8'h00, 8'h00};
        f_over  = '{8'h05, 8'h00};
        f_full  = '{8'h04, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h2F};
        f_part  = '{8'h04, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56};

        idle(3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_en = 1'b1;
        check("rst_ready", {63'd0, bus.byte_ready}, 64'd0);
        check("rst_we", {63'd0, bus.imem_we}, 64'd0);
        check("rst_addr", {62'd0, bus.imem_addr}, 64'd0);
        check("rst_wdata", {32'd0, bus.imem_wdata}, 64'd0);
        check("rst_flags", {60'd0, cpu_reset, busy, done, error}, 64'b1000);

        // Pin the model against hand-computed checksums and word packing.
        check("pin_csum_basic", {56'd0, xor_bytes(f_basic, 10)}, 64'h63);
        check("pin_csum_full", {56'd0, xor_bytes(f_full, 18)}, 64'h2F);
        begin
            logic ok;
            ok = model_frame(f_basic);
            check("pin_basic_ok", {63'd0, ok}, 64'd1);
            check("pin_basic_w0", {30'd0, exp_q[0]}, {30'd0, 2'd0, 32'h00500093});
            check("pin_basic_w1", {30'd0, exp_q[1]}, {30'd0, 2'd1, 32'h00108133});
            exp_q.delete();
        end

        // Basic load, then bytes offered in DONE must be refused.
        run_frame(f_basic, 1'b0, 1'b0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("done_ready_low", {63'd0, bus.byte_ready}, 64'd0);
            check("done_held", {63'd0, done}, 64'd1);
        end
        bus.byte_valid = 1'b0;

        run_frame(f_bad, 1'b0, 1'b0);
        run_frame(f_zero, 1'b0, 1'b0);
        run_frame(f_over, 1'b0, 1'b0);

        // Full-capacity frame with random gaps and a start pulse that must be ignored.
        begin
            logic ok;
            ok = model_frame(f_full);
            check("pin_full_ok", {63'd0, ok}, 64'd1);
            check("pin_full_w3", {30'd0, exp_q[3]}, {30'd0, 2'd3, 32'h00000001});
            exp_q.delete();
        end
        run_frame(f_full, 1'b1, 1'b1);

        // Reset in the middle of DATA after six payload bytes.
        wr_count = 0;
        pulse_start();
        exp_q.push_back({2'd0, 32'hDEADBEEF});
        for (int i = 0; i < f_part.size(); i++) send_byte(f_part[i], 1'b0);
        reset = 1'b1;
        idle(1);
        check("midrst_ready", {63'd0, bus.byte_ready}, 64'd0);
        check("midrst_we", {63'd0, bus.imem_we}, 64'd0);
        check("midrst_addr_data", {30'd0, bus.imem_addr, bus.imem_wdata}, 64'd0);
        check("midrst_flags", {60'd0, cpu_reset, busy, done, error}, 64'b1000);
        reset = 1'b0;
        idle(4);
        check("midrst_writes", 64'(wr_count), 64'd1);
        check("midrst_exp_q", 64'(exp_q.size()), 64'd0);

        run_frame(f_full, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
